dmem_responder: RTL

Data-side memory responder for the pipelined CPU's data port (`mem_addr`, `mem_we`, `mem_re`, `mem_byte_slct`, `data_to_write_mem`, `data_from_mem`). It answers the CPU's loads and stores from a word-organised RAM with byte-lane writes. It also decodes a small MMIO window containing:
- a console TX FIFO with a valid/ready drain port,
- a status register,
- a free-running cycle counter,
- a sticky halt flag.

It replaces the behavioural RAM in SOPC-level benches and lets test programs report results and stop simulation.

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM with byte-lane writes plus a small
// MMIO window (console FIFO, status, cycle counter, sticky halt).
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr_i,
  input  logic [3:0]  byte_slct,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready,
  output logic        halt,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] OFF_CONS   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;
  localparam logic [1:0] OFF_HALT   = 2'd3;

  logic [31:0]      mem_data [0:DEPTH_WORDS-1];
  logic [7:0]       fifo_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             overflow;
  logic [31:0]      cycle_cnt;

  logic             ram_hit;
  logic             mmio_hit;
  logic             unmapped;
  logic [IDX_W-1:0] ram_idx;
  logic [1:0]       mmio_off;
  logic             mmio_wr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             ovf_clr;
  logic             cycle_ld;
  logic [31:0]      mmio_rdata;
  logic             unused_addr_lsb;

  // Address decode; RAM wins if a misconfiguration ever overlaps the regions
  assign ram_hit  = (addr_i[31:IDX_W+2] == '0);
  assign mmio_hit = (addr_i[31:4] == MMIO_BASE[31:4]);
  assign unmapped = !ram_hit && !mmio_hit;
  assign ram_idx  = addr_i[IDX_W+1:2];
  assign mmio_off = addr_i[3:2];
  assign mmio_wr  = we && !ram_hit && mmio_hit;
  assign unused_addr_lsb = ^addr_i[1:0];

  // FIFO handshake: a push into a full FIFO survives only if a pop frees a slot
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign push_req   = mmio_wr && (mmio_off == OFF_CONS) && byte_slct[0];
  assign pop        = !fifo_empty && cons_ready;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_clr    = mmio_wr && (mmio_off == OFF_STATUS) && byte_slct[0] && data_i[2];
  assign cycle_ld   = mmio_wr && (mmio_off == OFF_CYCLE) && (byte_slct == 4'hF);

  assign cons_valid = !fifo_empty;
  assign cons_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  // MMIO read mux
  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_off)
      OFF_STATUS: mmio_rdata = {29'b0, overflow, fifo_full, fifo_empty};
      OFF_CYCLE:  mmio_rdata = cycle_cnt;
      OFF_HALT:   mmio_rdata = {31'b0, halt};
      default:    mmio_rdata = 32'h0;
    endcase
  end

  // Zero-latency load path; unmapped or idle reads return 0
  always_comb begin
    data_o = 32'h0;
    if (ce) begin
      if (ram_hit) begin
        data_o = mem_data[ram_idx];
      end else if (mmio_hit) begin
        data_o = mmio_rdata;
      end
    end
  end

  // RAM byte-lane store; array is never cleared so preloads survive reset
  always_ff @(posedge clk) begin
    if (we && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_slct[i]) begin
          mem_data[ram_idx][8*i +: 8] <= data_i[8*i +: 8];
        end
      end
    end
  end

  // Console FIFO storage; stale entries are unreachable once pointers reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= data_i[7:0];
    end
  end

  // Control state: FIFO pointers/count, overflow, cycle counter, sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
      overflow  <= 1'b0;
      cycle_cnt <= 32'h0;
      halt      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (pop && !push_ok) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end

      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      if (cycle_ld) begin
        cycle_cnt <= data_i;
      end else begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end

      if (mmio_wr && (mmio_off == OFF_HALT)) begin
        halt <= 1'b1;
      end
      if ((ce || we) && unmapped) begin
        err <= 1'b1;
      end
    end
  end

endmodule
